// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB plus a 2-bit PHT indexed bimodally or by gshare.
// Lookup is combinational on the fetch PC; resolved EX results update state on the rising edge.
module branch_predictor #(
    parameter int BTB_ENTRIES = 32,
    parameter int HIST_BITS   = 5,
    parameter int MODE        = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      lookup_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic             upd_is_branch,
    input  logic             upd_is_jump,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             upd_mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int PHT_N = 1 << HIST_BITS;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [BTB_ENTRIES-1:0] btb_jump;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [31:0]            btb_target [BTB_ENTRIES];
    logic [1:0]             pht        [PHT_N];
    logic [HIST_BITS-1:0]   ghr;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
        return pc[31:IDX_W+2];
    endfunction

    function automatic logic [HIST_BITS-1:0] pht_idx(input logic [31:0] pc,
                                                     input logic [HIST_BITS-1:0] hist);
        if (MODE == 2) return pc[HIST_BITS+1:2] ^ hist;
        return pc[HIST_BITS+1:2];
    endfunction

    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Shift form works for every width, including a single history bit.
    function automatic logic [HIST_BITS-1:0] ghr_next(input logic [HIST_BITS-1:0] h,
                                                      input logic t);
        return (h << 1) | HIST_BITS'(t);
    endfunction

    logic [IDX_W-1:0]     l_idx;
    logic                 l_hit;
    logic [HIST_BITS-1:0] l_pidx;
    logic [IDX_W-1:0]     u_idx;
    logic [HIST_BITS-1:0] u_pidx;
    logic                 btb_we;
    logic                 pht_we;
    logic                 unused_lsb;

    assign l_idx  = idx_of(lookup_pc);
    assign l_hit  = btb_valid[l_idx] && (btb_tag[l_idx] == tag_of(lookup_pc));
    assign l_pidx = pht_idx(lookup_pc, ghr);

    assign pred_taken  = (MODE != 0) && l_hit && (btb_jump[l_idx] || pht[l_pidx][1]);
    assign pred_target = pred_taken ? btb_target[l_idx] : lookup_pc + 32'd4;

    assign upd_mispredict = upd_valid && ((upd_pred_taken != upd_taken) ||
                                          (upd_taken && (upd_pred_target != upd_target)));

    assign u_idx  = idx_of(upd_pc);
    assign u_pidx = pht_idx(upd_pc, ghr);
    assign btb_we = (MODE != 0) && upd_valid && upd_taken && (upd_is_branch || upd_is_jump);
    assign pht_we = (MODE != 0) && upd_valid && upd_is_branch;

    assign unused_lsb = &{1'b0, upd_pc[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_valid   <= '0;
            ghr         <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
        end else begin
            if (btb_we) btb_valid[u_idx] <= 1'b1;
            if (pht_we) begin
                pht[u_pidx] <= sat_ctr(pht[u_pidx], upd_taken);
                ghr         <= ghr_next(ghr, upd_taken);
            end
            if (upd_valid)      branch_cnt  <= sat_inc(branch_cnt);
            if (upd_mispredict) mispred_cnt <= sat_inc(mispred_cnt);
        end
    end

    // Entry payload is qualified by btb_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag[u_idx]    <= tag_of(upd_pc);
            btb_target[u_idx] <= upd_target;
            btb_jump[u_idx]   <= upd_is_jump;
        end
    end

endmodule
